cla_sub_seq: RTL and testbench

CLA_SUB_SEQ -- requirements
Module: cla_sub_seq

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla8_cin.sv | 83 ++++++++
 rtl/cla_sub_seq.sv | 161 ++++++++++++++++
 tb/tb_cla_sub_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared definitions for the byte-serial carry-lookahead
//            subtractor. Holds the FSM state type, the slice width and the
//            default operand width in bytes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Sequencer states of cla_sub_seq.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the carry-lookahead slice, which is also the operand step per cycle.
    localparam int SLICE_W        = 8;

    // Default operand width in bytes.
    localparam int NBYTES_DEFAULT = 4;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla8_cin.sv
`default_nettype none
// ============================================================================
// Module   : cla8_cin
// Purpose  : Combinational 8-bit carry-lookahead adder with carry-in.
//            Bit-level generate/propagate feed two 4-bit lookahead groups.
//            A second lookahead level forms the group carries directly
//            from cin_i, so no carry ripples between the groups.
// Ports    : a_i    [7:0]  addend A
//            b_i    [7:0]  addend B
//            cin_i         carry in
//            sum_o  [7:0]  A + B + cin (low 8 bits)
//            cout_o        carry out of bit 7
// Revision : 1.0 - initial release
// ============================================================================
module cla8_cin
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    localparam int NGRP = SLICE_W / 4;

    logic [SLICE_W-1:0] w_g;     // bit generate
    logic [SLICE_W-1:0] w_p;     // bit propagate
    logic [SLICE_W-1:0] w_c;     // carry into each bit
    logic [NGRP-1:0]    w_gg;    // group generate
    logic [NGRP-1:0]    w_gp;    // group propagate
    logic [NGRP-1:0]    w_gcin;  // carry into each group

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    // First level: group generate/propagate.
    generate
        for (genvar k = 0; k < NGRP; k++) begin : g_grp
            logic [3:0] w_gk;
            logic [3:0] w_pk;
            assign w_gk    = w_g[4*k +: 4];
            assign w_pk    = w_p[4*k +: 4];
            assign w_gg[k] = w_gk[3]
                           | (w_pk[3] & w_gk[2])
                           | (w_pk[3] & w_pk[2] & w_gk[1])
                           | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]);
            assign w_gp[k] = &w_pk;
        end
    endgenerate

    // Second level: group carries taken straight from cin_i.
    assign w_gcin[0] = cin_i;
    assign w_gcin[1] = w_gg[0] | (w_gp[0] & cin_i);
    assign cout_o    = w_gg[1]
                     | (w_gp[1] & w_gg[0])
                     | (w_gp[1] & w_gp[0] & cin_i);

    // Carries inside each group, expanded from the group carry-in.
    generate
        for (genvar k = 0; k < NGRP; k++) begin : g_bits
            logic [3:0] w_gk;
            logic [3:0] w_pk;
            logic       w_ci;
            assign w_gk = w_g[4*k +: 4];
            assign w_pk = w_p[4*k +: 4];
            assign w_ci = w_gcin[k];
            assign w_c[4*k + 0] = w_ci;
            assign w_c[4*k + 1] = w_gk[0] | (w_pk[0] & w_ci);
            assign w_c[4*k + 2] = w_gk[1]
                                | (w_pk[1] & w_gk[0])
                                | (w_pk[1] & w_pk[0] & w_ci);
            assign w_c[4*k + 3] = w_gk[2]
                                | (w_pk[2] & w_gk[1])
                                | (w_pk[2] & w_pk[1] & w_gk[0])
                                | (w_pk[2] & w_pk[1] & w_pk[0] & w_ci);
        end
    endgenerate

    assign sum_o = w_p ^ w_c;

endmodule : cla8_cin
`default_nettype wire

// File: rtl/cla_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_sub_seq
// Purpose  : Byte-serial unsigned subtractor. It computes a + ~b + 1 one byte
//            per cycle, LSB byte first, through a single reused cla8_cin
//            slice. It uses a valid/ready handshake on both sides.
// Params   : NBYTES  operand width in bytes (1..16), W = 8*NBYTES
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready / a[W-1:0] / b[W-1:0]   operand handshake
//            out_valid / out_ready                       result handshake
//            diff[W-1:0]  a - b mod 2^W
//            borrow       unsigned a < b
//            zero         diff == 0
//            ovf          signed overflow (only with CLA_SUB_OVF_EN defined)
// Config   : `define CLA_SUB_OVF_EN adds the ovf output and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLICE_W*NBYTES-1:0] a,
    input  logic [SLICE_W*NBYTES-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SLICE_W*NBYTES-1:0] diff,
    output logic                    borrow,
    output logic                    zero
`ifdef CLA_SUB_OVF_EN
    ,
    output logic                    ovf
`endif
);

    localparam int W     = SLICE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t             state_q;
    logic [W-1:0]       a_q;        // captured minuend
    logic [W-1:0]       bn_q;       // captured, inverted subtrahend
    logic [W-1:0]       acc_q;      // working result, published on completion
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       diff_q;
    logic               borrow_q;
    logic               zero_q;
    logic               in_ready_q;
    logic               out_valid_q;
`ifdef CLA_SUB_OVF_EN
    logic               ovf_q;
`endif

    logic [IDX_W+2:0]   w_base;     // bit offset of the current byte
    logic [SLICE_W-1:0] w_a_byte;
    logic [SLICE_W-1:0] w_bn_byte;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic               w_last;
    logic [W-1:0]       acc_d;

    assign w_base = {idx_q, 3'b000};
    assign w_last = (idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        w_a_byte  = a_q[w_base +: SLICE_W];
        w_bn_byte = bn_q[w_base +: SLICE_W];
        acc_d     = acc_q;
        acc_d[w_base +: SLICE_W] = w_sum;
    end

    cla8_cin u_slice (
        .a_i    (w_a_byte),
        .b_i    (w_bn_byte),
        .cin_i  (carry_q),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // The sequencer keeps every externally visible output registered.
    // The result is built in acc_q and copied to diff_q only on the final
    // byte. So diff/borrow/zero keep their last values outside DONE, and
    // an aborted operation never reaches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            bn_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        bn_q       <= ~b;
                        carry_q    <= 1'b1;   // the +1 of a + ~b + 1
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= w_cout;
                    if (w_last) begin
                        diff_q      <= acc_d;
                        borrow_q    <= ~w_cout;
                        zero_q      <= (acc_d == '0);
`ifdef CLA_SUB_OVF_EN
                        // Signs of a and b differ (bn holds ~b) and the result sign differs from a.
                        ovf_q       <= (a_q[W-1] == bn_q[W-1]) & (acc_d[W-1] != a_q[W-1]);
`endif
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
`ifdef CLA_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : cla_sub_seq
`default_nettype wire

// File: tb/tb_cla_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_sub_seq
// Purpose  : Self-checking bench for cla_sub_seq (NBYTES = 4). It drives
//            random and directed operand pairs and compares the results
//            with an arithmetic reference model.
// Config   : checks ovf as well when CLA_SUB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_sub_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
`ifdef CLA_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_sub_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned d;
        d = longint'(x) + (longint'(1) << W) - longint'(y);
        return d[W-1:0];
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x < y);
    endfunction

    function automatic logic m_zero(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x == y);
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sd;
        sd = longint'($signed(x)) - longint'($signed(y));
        return (sd > longint'(32'sh7FFFFFFF)) || (sd < -longint'(64'h80000000));
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Presents one operand pair for a single cycle; returns #1 after the accept edge.
    task automatic drive_accept(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 40);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b diff=%h bw=%b z=%b, want 0/0/0/0",
                     out_valid, diff, borrow, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4] = '{32'd5, 32'd3, 32'h00000100, 32'hDEADBEEF};
        logic [W-1:0] vb[4] = '{32'd3, 32'd5, 32'h00000001, 32'hDEADBEEF};
        logic [W-1:0] ed[4] = '{32'h00000002, 32'hFFFFFFFE, 32'h000000FF, 32'h00000000};
        logic         eb[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         ez[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            drive_accept(va[i], vb[i]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL dir_in_ready_run[%0d]: got %b want 0", i, in_ready);
            end
            wait_out(cyc);
            checks++;
            if (cyc != NB) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d want %0d", i, cyc, NB);
            end
            checks++;
            if (diff !== ed[i] || borrow !== eb[i] || zero !== ez[i] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL dir_result[%0d]: got diff=%h bw=%b z=%b ir=%b, want %h/%b/%b/0",
                         i, diff, borrow, zero, in_ready, ed[i], eb[i], ez[i]);
            end
            finish_op();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_handshake[%0d]: got ov=%b ir=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, pd;
        logic         pb, pz, have_prev;
        int cyc, mode;
        have_prev = 1'b0;
        pd = '0; pb = 1'b0; pz = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 4);
            x = $urandom;
            y = $urandom;
            case (mode)
                1: y = x;
                2: y = '0;
                3: x = '0;
                4: y = x + 32'($urandom_range(0, 2));
                default: ;
            endcase
            drive_accept(x, y);
            if (have_prev) begin
                checks++;
                if (diff !== pd || borrow !== pb || zero !== pz) begin
                    errors++;
                    $display("FAIL rnd_hold[%0d]: got diff=%h bw=%b z=%b, want %h/%b/%b",
                             i, diff, borrow, zero, pd, pb, pz);
                end
            end
            wait_out(cyc);
            pd = m_diff(x, y);
            pb = m_borrow(x, y);
            pz = m_zero(x, y);
            have_prev = 1'b1;
            checks++;
            if (cyc != NB || diff !== pd || borrow !== pb || zero !== pz) begin
                errors++;
                $display("FAIL rnd_result[%0d]: a=%h b=%h got lat=%0d diff=%h bw=%b z=%b, want %0d/%h/%b/%b",
                         i, x, y, cyc, diff, borrow, zero, NB, pd, pb, pz);
            end
`ifdef CLA_SUB_OVF_EN
            checks++;
            if (ovf !== m_ovf(x, y)) begin
                errors++;
                $display("FAIL rnd_ovf[%0d]: a=%h b=%h got %b want %b", i, x, y, ovf, m_ovf(x, y));
            end
`endif
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, y, ed;
        logic         eb, ez;
        int cyc;
        x = $urandom;
        y = $urandom;
        ed = m_diff(x, y);
        eb = m_borrow(x, y);
        ez = m_zero(x, y);
        drive_accept(x, y);
        wait_out(cyc);
        checks++;
        if (cyc != NB) begin
            errors++;
            $display("FAIL bp_latency: got %0d want %0d", cyc, NB);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || borrow !== eb || zero !== ez) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got ov=%b ir=%b diff=%h bw=%b z=%b, want 1/0/%h/%b/%b",
                         i, out_valid, in_ready, diff, borrow, zero, ed, eb, ez);
            end
        end
        @(negedge clk);
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== ed) begin
                errors++;
                $display("FAIL bp_no_capture[%0d]: got ov=%b ir=%b diff=%h, want 0/1/%h",
                         i, out_valid, in_ready, diff, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] expq[$];
        logic [W+1:0] e;
        int           acc_t[$];
        logic [W-1:0] x, y;
        int nsent, ngot;
        nsent = 0;
        ngot  = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && ngot < 4; t++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: got out_valid=1 want no result pending");
                end else begin
                    e = expq.pop_front();
                    if ({borrow, zero, diff} !== e) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got bw=%b z=%b diff=%h, want %b/%b/%h",
                                 ngot, borrow, zero, diff, e[W+1], e[W], e[W-1:0]);
                    end
                end
                ngot++;
            end
            if (in_ready && nsent < 4) begin
                x = $urandom;
                y = $urandom;
                a = x;
                b = y;
                in_valid = 1'b1;
                acc_t.push_back(t);
                expq.push_back({m_borrow(x, y), m_zero(x, y), m_diff(x, y)});
                nsent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (ngot != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 4", ngot);
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++;
            if (acc_t[i] - acc_t[i-1] != NB + 2) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", i, acc_t[i] - acc_t[i-1], NB + 2);
            end
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        // Leave a non-zero result in place so that the clear is visible.
        drive_accept(32'h00001000, 32'h00000001);
        wait_out(cyc);
        finish_op();
        drive_accept(32'hAAAA5555, 32'h00001111);
        @(posedge clk);          // first RUN byte done, now in the second RUN cycle
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: got ov=%b ir=%b diff=%h bw=%b z=%b, want 0/1/0/0/0",
                     out_valid, in_ready, diff, borrow, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: got ov=%b ir=%b want 0/1", i, out_valid, in_ready);
            end
        end
        drive_accept(32'd7, 32'd2);
        wait_out(cyc);
        checks++;
        if (cyc != NB || diff !== 32'd5 || borrow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_op: got lat=%0d diff=%h bw=%b z=%b, want %0d/00000005/0/0",
                     cyc, diff, borrow, zero, NB);
        end
        finish_op();
    endtask

`ifdef CLA_SUB_OVF_EN
    task automatic test_ovf();
        int cyc;
        drive_accept(32'h80000000, 32'h00000001);
        wait_out(cyc);
        checks++;
        if (diff !== 32'h7FFFFFFF || ovf !== 1'b1 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: got diff=%h ovf=%b bw=%b, want 7fffffff/1/0", diff, ovf, borrow);
        end
        finish_op();
        drive_accept(32'd5, 32'd3);
        wait_out(cyc);
        checks++;
        if (diff !== 32'd2 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got diff=%h ovf=%b, want 00000002/0", diff, ovf);
        end
        finish_op();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
`ifdef CLA_SUB_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cla_sub_seq
`default_nettype wire
